ahb_slave_if: RTL and testbench

- AHB-side front end of the AHB2APB bridge; sits directly upstream of the APB FSM controller.
- Decodes each AHB transfer into `valid` and the one-hot APB slave select `tempselx`.
- Registers a two-deep address/write-data pipeline (`Haddr1`/`Haddr2`, `Hwdata1`/`Hwdata2`) plus `Hwritereg`; the FSM controller consumes these.
- Passes `Prdata` back as `Hrdata`; optionally generates the two-cycle AHB ERROR response for unmapped addresses.

---
 rtl/ahb_apb_pkg.sv | 27 ++
 rtl/ahb_addr_decoder.sv | 33 +++
 rtl/ahb_slave_if.sv | 116 +++++++++++
 tb/tb_ahb_slave_if.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ahb_apb_pkg : shared AHB/APB constants, address defaults, error FSM   |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
  localparam logic [31:0] DEF_SLV_SPAN  = 32'h0400_0000;
  localparam int          DEF_NUM_SLV   = 3;

  typedef enum logic [1:0] {
    E_IDLE = 2'd0,
    E_ERR1 = 2'd1,
    E_ERR2 = 2'd2
  } err_state_e;

endpackage
`default_nettype wire

// File: rtl/ahb_addr_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ahb_addr_decoder : combinational bridge-window and one-hot slave      |
// |                    select decode of the AHB address                   |
// | Revision         : 1.0                                                |
// +-----------------------------------------------------------------------+
module ahb_addr_decoder
  import ahb_apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [31:0] SLV_SPAN  = DEF_SLV_SPAN,
  parameter int          NUM_SLV   = DEF_NUM_SLV
) (
  input  logic [31:0]        haddr_i,
  output logic               in_win_o,
  output logic [NUM_SLV-1:0] tempselx_o
);

  // 33-bit compares keep region upper bounds from wrapping past 4 GiB
  logic [32:0] w_addr;
  assign w_addr = {1'b0, haddr_i};

  for (genvar i = 0; i < NUM_SLV; i++) begin : g_sel
    localparam logic [32:0] LO = {1'b0, BASE_ADDR} + 33'(i) * {1'b0, SLV_SPAN};
    localparam logic [32:0] HI = LO + {1'b0, SLV_SPAN};
    assign tempselx_o[i] = (w_addr >= LO) && (w_addr < HI);
  end

  // Slave regions are contiguous, so the window is their union
  assign in_win_o = |tempselx_o;

endmodule
`default_nettype wire

// File: rtl/ahb_slave_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ahb_slave_if : AHB front end of the AHB2APB bridge -- transfer decode,|
// |                two-deep addr/data pipeline, optional ERROR response   |
// |                (enabled by defining AHB_ERR_RESP_EN)                  |
// | Revision     : 1.0                                                    |
// +-----------------------------------------------------------------------+
module ahb_slave_if
  import ahb_apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [31:0] SLV_SPAN  = DEF_SLV_SPAN,
  parameter int          NUM_SLV   = DEF_NUM_SLV
) (
  input  logic               Hclk,
  input  logic               Hreset,
  input  logic               Hwrite,
  input  logic               Hreadyin,
  input  logic [1:0]         Htrans,
  input  logic [31:0]        Haddr,
  input  logic [31:0]        Hwdata,
  input  logic [31:0]        Prdata,
  output logic               valid,
  output logic [NUM_SLV-1:0] tempselx,
  output logic [31:0]        Haddr1,
  output logic [31:0]        Haddr2,
  output logic [31:0]        Hwdata1,
  output logic [31:0]        Hwdata2,
  output logic               Hwritereg,
  output logic [31:0]        Hrdata,
  output logic [1:0]         Hresp,
  output logic               Hready_err
);

  logic        w_in_win;
  logic        w_xfer;
  logic        w_legal;
  logic [31:0] haddr1_q, haddr2_q, hwdata1_q, hwdata2_q;
  logic        hwrite_q;

  ahb_addr_decoder #(
    .BASE_ADDR (BASE_ADDR),
    .SLV_SPAN  (SLV_SPAN),
    .NUM_SLV   (NUM_SLV)
  ) u_dec (
    .haddr_i    (Haddr),
    .in_win_o   (w_in_win),
    .tempselx_o (tempselx)
  );

  assign w_xfer  = (Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ);
  assign w_legal = Hreadyin && w_xfer && w_in_win;

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      haddr1_q  <= '0;
      haddr2_q  <= '0;
      hwdata1_q <= '0;
      hwdata2_q <= '0;
      hwrite_q  <= 1'b0;
    end else if (Hreadyin) begin
      haddr1_q  <= Haddr;
      haddr2_q  <= haddr1_q;
      hwdata1_q <= Hwdata;
      hwdata2_q <= hwdata1_q;
      hwrite_q  <= Hwrite;
    end
  end

  assign Haddr1    = haddr1_q;
  assign Haddr2    = haddr2_q;
  assign Hwdata1   = hwdata1_q;
  assign Hwdata2   = hwdata2_q;
  assign Hwritereg = hwrite_q;
  assign Hrdata    = Prdata;

`ifdef AHB_ERR_RESP_EN
  err_state_e state_q, state_d;
  logic       w_unmapped;

  assign w_unmapped = Hreadyin && w_xfer && !w_in_win;

  always_ff @(posedge Hclk) begin
    if (Hreset) state_q <= E_IDLE;
    else        state_q <= state_d;
  end

  // Two-cycle ERROR: first cycle stalls the master, second completes it
  always_comb begin
    state_d    = state_q;
    Hresp      = HRESP_OKAY;
    Hready_err = 1'b1;
    case (state_q)
      E_IDLE: if (w_unmapped) state_d = E_ERR1;
      E_ERR1: begin
        Hresp      = HRESP_ERROR;
        Hready_err = 1'b0;
        state_d    = E_ERR2;
      end
      E_ERR2: begin
        Hresp   = HRESP_ERROR;
        state_d = w_unmapped ? E_ERR1 : E_IDLE;
      end
      default: state_d = E_IDLE;
    endcase
  end

  assign valid = w_legal && (state_q != E_ERR1);
`else
  assign Hresp      = HRESP_OKAY;
  assign Hready_err = 1'b1;
  assign valid      = w_legal;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_ahb_slave_if : self-checking bench for ahb_slave_if                |
// | Revision        : 1.0                                                 |
// +-----------------------------------------------------------------------+
module tb_ahb_slave_if;

  logic        Hclk = 1'b0;
  logic        Hreset, Hwrite, Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr, Hwdata, Prdata;
  logic        valid, Hwritereg, Hready_err;
  logic [2:0]  tempselx;
  logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2, Hrdata;
  logic [1:0]  Hresp;

  int n_checks = 0;
  int n_pass   = 0;

  // reference pipeline contents
  logic [31:0] m_a1, m_a2, m_w1, m_w2;
  logic        m_wr;

  always #5 Hclk = ~Hclk;

  ahb_slave_if dut (
    .Hclk       (Hclk),
    .Hreset     (Hreset),
    .Hwrite     (Hwrite),
    .Hreadyin   (Hreadyin),
    .Htrans     (Htrans),
    .Haddr      (Haddr),
    .Hwdata     (Hwdata),
    .Prdata     (Prdata),
    .valid      (valid),
    .tempselx   (tempselx),
    .Haddr1     (Haddr1),
    .Haddr2     (Haddr2),
    .Hwdata1    (Hwdata1),
    .Hwdata2    (Hwdata2),
    .Hwritereg  (Hwritereg),
    .Hrdata     (Hrdata),
    .Hresp      (Hresp),
    .Hready_err (Hready_err)
  );

  // slave index from plain division of the offset into the window
  function automatic logic [2:0] exp_sel(input logic [31:0] a);
    longint la, idx;
    la = longint'(a);
    if (la >= 64'h8000_0000 && la < 64'h8000_0000 + 3 * 64'h0400_0000) begin
      idx = (la - 64'h8000_0000) / 64'h0400_0000;
      return 3'(1 << idx);
    end
    return 3'b000;
  endfunction

  task automatic step();
    @(posedge Hclk);
    if (Hreset) begin
      m_a1 = '0; m_a2 = '0; m_w1 = '0; m_w2 = '0; m_wr = 1'b0;
    end else if (Hreadyin) begin
      m_a2 = m_a1; m_a1 = Haddr;
      m_w2 = m_w1; m_w1 = Hwdata;
      m_wr = Hwrite;
    end
    #1;
  endtask

  task automatic drive(input logic rdy, input logic [1:0] tr, input logic [31:0] a,
                       input logic wr, input logic [31:0] wd);
    Hreadyin = rdy; Htrans = tr; Haddr = a; Hwrite = wr; Hwdata = wd;
    Prdata = $urandom;
    #1;
  endtask

  task automatic test_reset();
    Hreset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'($urandom), $urandom, 1'($urandom), $urandom);
      step();
    end
    n_checks++;
    if ({Haddr1, Haddr2, Hwdata1, Hwdata2} !== 128'd0)
      $display("FAIL reset_pipe: got %h %h %h %h want all 0", Haddr1, Haddr2, Hwdata1, Hwdata2);
    else n_pass++;
    n_checks++;
    if (Hwritereg !== 1'b0) $display("FAIL reset_hwritereg: got %b want 0", Hwritereg);
    else n_pass++;
    n_checks++;
    if (Hresp !== 2'b00 || Hready_err !== 1'b1)
      $display("FAIL reset_resp: got resp=%b rdy=%b want 00/1", Hresp, Hready_err);
    else n_pass++;
    Hreset = 1'b0;
  endtask

  task automatic test_write();
    drive(1'b1, 2'b10, 32'h8400_0010, 1'b1, 32'hA5A5_0001);
    n_checks++;
    if (valid !== 1'b1 || tempselx !== 3'b010)
      $display("FAIL write_decode: got valid=%b sel=%b want 1/010", valid, tempselx);
    else n_pass++;
    step();
    drive(1'b1, 2'b00, 32'h0000_0000, 1'b0, 32'h0);
    n_checks++;
    if (Haddr1 !== 32'h8400_0010 || Hwritereg !== 1'b1 || Hwdata1 !== 32'hA5A5_0001)
      $display("FAIL write_stage1: got a1=%h wr=%b d1=%h want 84000010/1/a5a50001",
               Haddr1, Hwritereg, Hwdata1);
    else n_pass++;
    step();
    n_checks++;
    if (Haddr2 !== 32'h8400_0010 || Hwdata2 !== 32'hA5A5_0001)
      $display("FAIL write_stage2: got a2=%h d2=%h want 84000010/a5a50001", Haddr2, Hwdata2);
    else n_pass++;
  endtask

  task automatic test_hold();
    logic [31:0] a1, a2, d1, d2;
    drive(1'b1, 2'b10, 32'h8000_1000, 1'b1, 32'h1111_2222); step();
    drive(1'b1, 2'b11, 32'h8000_1004, 1'b0, 32'h3333_4444); step();
    a1 = m_a1; a2 = m_a2; d1 = m_w1; d2 = m_w2;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b10, 32'h8800_0000 + 32'(i * 4), 1'($urandom), $urandom);
      step();
    end
    n_checks++;
    if (Haddr1 !== a1 || Haddr2 !== a2 || Hwdata1 !== d1 || Hwdata2 !== d2)
      $display("FAIL hold: got %h %h %h %h want %h %h %h %h",
               Haddr1, Haddr2, Hwdata1, Hwdata2, a1, a2, d1, d2);
    else n_pass++;
  endtask

  task automatic test_boundary();
    logic [31:0] addrs [6];
    logic [2:0]  sels  [6];
    addrs = '{32'h7FFF_FFFC, 32'h8C00_0000, 32'h83FF_FFFC, 32'h8400_0000, 32'h8BFF_FFFC, 32'h8000_0000};
    sels  = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b100, 3'b001};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'b10, addrs[i], 1'b0, 32'h0);
      n_checks++;
      if (tempselx !== sels[i] || valid !== (sels[i] != 3'b000))
        $display("FAIL boundary_%h: got sel=%b valid=%b want %b/%b",
                 addrs[i], tempselx, valid, sels[i], sels[i] != 3'b000);
      else n_pass++;
    end
    drive(1'b1, 2'b01, 32'h8000_0000, 1'b0, 32'h0);
    n_checks++;
    if (valid !== 1'b0) $display("FAIL busy_valid: got %b want 0", valid);
    else n_pass++;
    drive(1'b1, 2'b00, 32'h8000_0000, 1'b0, 32'h0);
    n_checks++;
    if (valid !== 1'b0) $display("FAIL idle_valid: got %b want 0", valid);
    else n_pass++;
    step();
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0]  tr;
    logic        rdy, e_valid;
    int          errs;
    errs = 0;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0: a = 32'h8000_0000 + ($urandom % 32'h0C00_0000);
        1: a = 32'h7FFF_FFF0 + 32'($urandom_range(0, 16));
        2: a = $urandom;
        default: a = 32'h8C00_0000 - 32'h8 + 32'($urandom_range(0, 16));
      endcase
      tr  = 2'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
`ifdef AHB_ERR_RESP_EN
      if (exp_sel(a) == 3'b000) tr[1] = 1'b0;
`endif
      drive(rdy, tr, a, 1'($urandom), $urandom);
      e_valid = rdy && tr[1] && (exp_sel(a) != 3'b000);
      n_checks++;
      if (valid !== e_valid || tempselx !== exp_sel(a) || Hrdata !== Prdata
          || Hresp !== 2'b00 || Hready_err !== 1'b1) begin
        errs++;
        if (errs < 5)
          $display("FAIL rand_comb a=%h tr=%b rdy=%b: got v=%b sel=%b rd=%h resp=%b re=%b want v=%b sel=%b rd=%h resp=00 re=1",
                   a, tr, rdy, valid, tempselx, Hrdata, Hresp, Hready_err, e_valid, exp_sel(a), Prdata);
      end else n_pass++;
      step();
      n_checks++;
      if (Haddr1 !== m_a1 || Haddr2 !== m_a2 || Hwdata1 !== m_w1 || Hwdata2 !== m_w2 || Hwritereg !== m_wr) begin
        errs++;
        if (errs < 5)
          $display("FAIL rand_pipe: got %h %h %h %h %b want %h %h %h %h %b",
                   Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, m_a1, m_a2, m_w1, m_w2, m_wr);
      end else n_pass++;
    end
  endtask

`ifdef AHB_ERR_RESP_EN
  task automatic test_error();
    drive(1'b1, 2'b10, 32'h9000_0000, 1'b0, 32'h0); step();
    drive(1'b1, 2'b10, 32'h8000_0040, 1'b0, 32'h0);
    n_checks++;
    if (Hresp !== 2'b01 || Hready_err !== 1'b0 || valid !== 1'b0)
      $display("FAIL err_cyc1: got resp=%b re=%b v=%b want 01/0/0", Hresp, Hready_err, valid);
    else n_pass++;
    drive(1'b1, 2'b00, 32'h0, 1'b0, 32'h0); step();
    n_checks++;
    if (Hresp !== 2'b01 || Hready_err !== 1'b1)
      $display("FAIL err_cyc2: got resp=%b re=%b want 01/1", Hresp, Hready_err);
    else n_pass++;
    step();
    n_checks++;
    if (Hresp !== 2'b00 || Hready_err !== 1'b1)
      $display("FAIL err_cyc3: got resp=%b re=%b want 00/1", Hresp, Hready_err);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b10, 32'h9000_0000, 1'b0, 32'h0); step();
    drive(1'b1, 2'b00, 32'h0, 1'b0, 32'h0); step();
    drive(1'b1, 2'b11, 32'hA000_0000, 1'b0, 32'h0); step();
    n_checks++;
    if (Hresp !== 2'b01 || Hready_err !== 1'b0)
      $display("FAIL b2b_reenter: got resp=%b re=%b want 01/0", Hresp, Hready_err);
    else n_pass++;
    drive(1'b1, 2'b00, 32'h0, 1'b0, 32'h0); step(); step();
    n_checks++;
    if (Hresp !== 2'b00 || Hready_err !== 1'b1)
      $display("FAIL b2b_exit: got resp=%b re=%b want 00/1", Hresp, Hready_err);
    else n_pass++;
  endtask

  task automatic test_reset_in_err();
    drive(1'b1, 2'b10, 32'h9000_0000, 1'b0, 32'h0); step();
    Hreset = 1'b1;
    drive(1'b1, 2'b00, 32'h0, 1'b0, 32'h0); step();
    Hreset = 1'b0;
    #1;
    n_checks++;
    if (Hresp !== 2'b00 || Hready_err !== 1'b1)
      $display("FAIL err_reset: got resp=%b re=%b want 00/1", Hresp, Hready_err);
    else n_pass++;
  endtask
`else
  task automatic test_unmapped_dropped();
    drive(1'b1, 2'b10, 32'h9000_0000, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (Hresp !== 2'b00 || Hready_err !== 1'b1 || valid !== 1'b0)
        $display("FAIL unmapped_cyc%0d: got resp=%b re=%b v=%b want 00/1/0", i, Hresp, Hready_err, valid);
      else n_pass++;
      step();
      drive(1'b1, 2'b00, 32'h0, 1'b0, 32'h0);
    end
  endtask
`endif

  initial begin
    Hreset = 1'b1; Hwrite = 1'b0; Hreadyin = 1'b0; Htrans = 2'b00;
    Haddr = '0; Hwdata = '0; Prdata = '0;
    m_a1 = '0; m_a2 = '0; m_w1 = '0; m_w2 = '0; m_wr = 1'b0;
    #2;
    test_reset();
    test_write();
    test_hold();
    test_boundary();
`ifdef AHB_ERR_RESP_EN
    test_error();
    test_back_to_back();
    test_reset_in_err();
`else
    test_unmapped_dropped();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
